// File: rtl/fetch_cycle_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// One request is accepted per gnt, and each accepted request gets exactly one rvalid.
interface fetch_cycle_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_gnt,
    input  i_imem_rvalid,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_gnt,
    output i_imem_rvalid,
    output i_imem_rdata
  );
endinterface

// File: rtl/fetch_cycle.sv
// Fetch stage with a single-outstanding imem request, a one-entry response buffer
// for decode stalls, and an IF/ID pipeline register driven by the hazard unit.
module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          i_clk,
  input  logic          i_reset,
  fetch_cycle_if.master imem,
  input  logic          StallF,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  output logic [31:0]   PCF,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCD,
  output logic [31:0]   PCPlus4D,
  output logic          InstrVldD
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        vld_q, vld_d;

  logic        req_s;
  logic        deliver_s;
  logic [31:0] deliver_instr_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] redirect_pc_s;

  assign pc_plus4_s    = pc_q + 32'd4;
  assign redirect_pc_s = {PCTargetE[31:2], 2'b00};

  // State register: FSM state, fetch PC, drop flag and response buffer
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_REQ;
      drop_q  <= 1'b0;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic; a redirect outranks everything and never delivers the in-flight word
  always_comb begin
    state_d         = state_q;
    drop_d          = drop_q;
    pc_d            = pc_q;
    buf_d           = buf_q;
    deliver_s       = 1'b0;
    deliver_instr_s = buf_q;
    case (state_q)
      S_REQ: begin
        if (req_s && imem.i_imem_gnt) begin
          state_d = S_WAIT;
          drop_d  = PCSrcE;
        end else begin
          state_d = S_REQ;
        end
        if (PCSrcE) begin
          pc_d = redirect_pc_s;
        end else begin
          pc_d = pc_q;
        end
      end
      S_WAIT: begin
        if (PCSrcE) begin
          pc_d = redirect_pc_s;
          if (imem.i_imem_rvalid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end else if (imem.i_imem_rvalid) begin
          if (drop_q) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else if (!StallD && !FlushD) begin
            deliver_s       = 1'b1;
            deliver_instr_s = imem.i_imem_rdata;
            pc_d            = pc_plus4_s;
            state_d         = S_REQ;
          end else begin
            // Decode busy or flushing: park the word so it is delivered later, not lost
            buf_d   = imem.i_imem_rdata;
            state_d = S_HOLD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pc_d    = redirect_pc_s;
          state_d = S_REQ;
        end else if (!StallD && !FlushD) begin
          deliver_s       = 1'b1;
          deliver_instr_s = buf_q;
          pc_d            = pc_plus4_s;
          state_d         = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Output logic: imem request and visible fetch PC
  always_comb begin
    req_s            = (state_q == S_REQ) && !StallF && !i_reset;
    imem.o_imem_req  = req_s;
    imem.o_imem_addr = pc_q;
    PCF              = pc_q;
  end

  // IF/ID next value: flush > stall > delivery > bubble
  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    vld_d   = vld_q;
    if (FlushD) begin
      instr_d = NOP_INSTR;
      pcd_d   = 32'h0000_0000;
      pcp4_d  = 32'h0000_0000;
      vld_d   = 1'b0;
    end else if (StallD) begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      pcp4_d  = pcp4_q;
      vld_d   = vld_q;
    end else if (deliver_s) begin
      instr_d = deliver_instr_s;
      pcd_d   = pc_q;
      pcp4_d  = pc_plus4_s;
      vld_d   = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      pcd_d   = 32'h0000_0000;
      pcp4_d  = 32'h0000_0000;
      vld_d   = 1'b0;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'h0000_0000;
      pcp4_q  <= 32'h0000_0000;
      vld_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      vld_q   <= vld_d;
    end
  end

  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcp4_q;
  assign InstrVldD = vld_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed bench: expected fetch addresses and IF/ID deliveries are queued by the
// stimulus and popped by negedge monitors whenever the DUT accepts or delivers.
module tb_fetch_cycle;
  logic        clk;
  logic        i_reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        InstrVldD;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_cycle_if imem_if ();

  fetch_cycle dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .imem      (imem_if),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .InstrVldD (InstrVldD)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] addr_q[$];
  logic [95:0] del_q[$];
  logic        stall_at_edge = 1'b0;
  logic [31:0] mon_addr;
  logic [95:0] mon_del;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_del(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pcp4);
    del_q.push_back({instr, pc, pcp4});
  endtask

  always @(posedge clk) stall_at_edge <= StallD;

  // Address monitor: every accepted request must match the next queued address
  always @(negedge clk) begin
    if (imem_if.o_imem_req && imem_if.i_imem_gnt) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_request actual=%h expected=none", imem_if.o_imem_addr);
      end else begin
        mon_addr = addr_q.pop_front();
        check("imem_addr", imem_if.o_imem_addr, mon_addr);
      end
    end
  end

  // Delivery monitor: a valid IF/ID after a non-stalled edge is a fresh delivery
  always @(negedge clk) begin
    if (InstrVldD && !stall_at_edge) begin
      if (del_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery actual=%h expected=none", InstrD);
      end else begin
        mon_del = del_q.pop_front();
        check("InstrD", InstrD, mon_del[95:64]);
        check("PCD", PCD, mon_del[63:32]);
        check("PCPlus4D", PCPlus4D, mon_del[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset = 1'b1;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0;
    imem_if.i_imem_gnt = 1'b0;
    imem_if.i_imem_rvalid = 1'b0;
    imem_if.i_imem_rdata = 32'h0;
    repeat (3) step();

    // Reset state
    check("rst_PCF", PCF, 32'h0);
    check("rst_req", {31'd0, imem_if.o_imem_req}, 32'd0);
    check("rst_InstrD", InstrD, NOP);
    check("rst_vld", {31'd0, InstrVldD}, 32'd0);
    check("rst_PCD", PCD, 32'h0);

    // Basic fetch: gnt immediately, rvalid next cycle
    i_reset = 1'b0; imem_if.i_imem_gnt = 1'b1; addr_q.push_back(32'h0);
    step();
    imem_if.i_imem_gnt = 1'b0; imem_if.i_imem_rvalid = 1'b1;
    imem_if.i_imem_rdata = 32'h0050_0093; exp_del(32'h0050_0093, 32'h0, 32'h4);
    step();
    imem_if.i_imem_rvalid = 1'b0;
    check("t1_PCF", PCF, 32'h4);
    check("t1_vld", {31'd0, InstrVldD}, 32'd1);

    // Response during a 3-cycle decode stall
    imem_if.i_imem_gnt = 1'b1; addr_q.push_back(32'h4);
    step();
    imem_if.i_imem_gnt = 1'b0; imem_if.i_imem_rvalid = 1'b1;
    imem_if.i_imem_rdata = 32'h0020_81B3; StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      imem_if.i_imem_rvalid = 1'b0;
      check("stall_req", {31'd0, imem_if.o_imem_req}, 32'd0);
      check("stall_InstrD", InstrD, NOP);
      check("stall_PCF", PCF, 32'h4);
    end
    StallD = 1'b0; exp_del(32'h0020_81B3, 32'h4, 32'h8);
    step();
    check("t2_PCF", PCF, 32'h8);

    // Two back-to-back fetches to reach PC 0x10
    for (int k = 0; k < 2; k++) begin
      imem_if.i_imem_gnt = 1'b1; addr_q.push_back(32'h8 + 32'd4 * k);
      step();
      imem_if.i_imem_gnt = 1'b0; imem_if.i_imem_rvalid = 1'b1;
      imem_if.i_imem_rdata = 32'h1111_1111 * (k + 1);
      exp_del(32'h1111_1111 * (k + 1), 32'h8 + 32'd4 * k, 32'hC + 32'd4 * k);
      step();
      imem_if.i_imem_rvalid = 1'b0;
    end
    check("t3_PCF", PCF, 32'h10);

    // Redirect while waiting: the in-flight word is dropped
    imem_if.i_imem_gnt = 1'b1; addr_q.push_back(32'h10);
    step();
    imem_if.i_imem_gnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h40;
    step();
    PCSrcE = 1'b0;
    check("redir_PCF", PCF, 32'h40);
    check("redir_vld", {31'd0, InstrVldD}, 32'd0);
    imem_if.i_imem_rvalid = 1'b1; imem_if.i_imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_if.i_imem_rvalid = 1'b0;
    check("drop_vld", {31'd0, InstrVldD}, 32'd0);
    imem_if.i_imem_gnt = 1'b1; addr_q.push_back(32'h40);
    step();
    imem_if.i_imem_gnt = 1'b0; imem_if.i_imem_rvalid = 1'b1;
    imem_if.i_imem_rdata = 32'h3333_3333; exp_del(32'h3333_3333, 32'h40, 32'h44);
    step();
    imem_if.i_imem_rvalid = 1'b0;

    // Misaligned redirect target is aligned down
    StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h43;
    step();
    PCSrcE = 1'b0; StallF = 1'b0;
    check("align_PCF", PCF, 32'h40);

    // Flush with a response pending: word is held and delivered afterwards
    imem_if.i_imem_gnt = 1'b1; addr_q.push_back(32'h40);
    step();
    imem_if.i_imem_gnt = 1'b0; imem_if.i_imem_rvalid = 1'b1;
    imem_if.i_imem_rdata = 32'h4444_4444; FlushD = 1'b1;
    step();
    imem_if.i_imem_rvalid = 1'b0;
    check("flush_vld", {31'd0, InstrVldD}, 32'd0);
    check("flush_PCF", PCF, 32'h40);
    FlushD = 1'b0; exp_del(32'h4444_4444, 32'h40, 32'h44);
    step();
    check("flush_after_PCF", PCF, 32'h44);

    // Redirect out of HOLD discards the buffered word
    imem_if.i_imem_gnt = 1'b1; addr_q.push_back(32'h44);
    step();
    imem_if.i_imem_gnt = 1'b0; imem_if.i_imem_rvalid = 1'b1;
    imem_if.i_imem_rdata = 32'h5555_5555; StallD = 1'b1;
    step();
    imem_if.i_imem_rvalid = 1'b0; StallD = 1'b0;
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    step();
    PCSrcE = 1'b0;
    check("hold_redir_PCF", PCF, 32'hFFFF_FFFC);
    check("hold_redir_vld", {31'd0, InstrVldD}, 32'd0);

    // PC wrap at the top of the address space
    imem_if.i_imem_gnt = 1'b1; addr_q.push_back(32'hFFFF_FFFC);
    step();
    imem_if.i_imem_gnt = 1'b0; imem_if.i_imem_rvalid = 1'b1;
    imem_if.i_imem_rdata = 32'h6666_6666; exp_del(32'h6666_6666, 32'hFFFF_FFFC, 32'h0);
    step();
    imem_if.i_imem_rvalid = 1'b0;
    check("wrap_PCF", PCF, 32'h0);

    // Reset while a response is outstanding
    imem_if.i_imem_gnt = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h80; addr_q.push_back(32'h0);
    step();
    PCSrcE = 1'b0; imem_if.i_imem_gnt = 1'b0;
    i_reset = 1'b1; imem_if.i_imem_rvalid = 1'b1; imem_if.i_imem_rdata = 32'h7777_7777;
    step();
    imem_if.i_imem_rvalid = 1'b0;
    check("mrst_PCF", PCF, 32'h0);
    check("mrst_vld", {31'd0, InstrVldD}, 32'd0);
    check("mrst_InstrD", InstrD, NOP);
    check("mrst_req", {31'd0, imem_if.o_imem_req}, 32'd0);
    step();
    i_reset = 1'b0;
    #1;
    check("post_rst_req", {31'd0, imem_if.o_imem_req}, 32'd1);
    check("post_rst_addr", imem_if.o_imem_addr, 32'h0);
    imem_if.i_imem_gnt = 1'b1; addr_q.push_back(32'h0);
    step();
    imem_if.i_imem_gnt = 1'b0; imem_if.i_imem_rvalid = 1'b1;
    imem_if.i_imem_rdata = 32'h8888_8888; exp_del(32'h8888_8888, 32'h0, 32'h4);
    step();
    imem_if.i_imem_rvalid = 1'b0;
    repeat (3) step();

    check("addr_q_left", addr_q.size(), 32'd0);
    check("del_q_left", del_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
